// File: rtl/axis_demux_n.sv
// AXI-Stream 1-to-N demultiplexer with a registered shared holding stage and discard of beats to absent channels.
// Define AXIS_DEMUX_PKT_LOCK_EN to route whole packets (up to s_tlast) to the channel selected on their first beat.
module axis_demux_n #(
    parameter int DATA_W = 32,
    parameter int N_OUT  = 3,
    parameter int SEL_W  = $clog2(N_OUT)
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [SEL_W-1:0]          demux_sel,
    input  logic [DATA_W-1:0]         s_tdata,
    input  logic                      s_tvalid,
    input  logic                      s_tlast,
    output logic                      s_tready,
    output logic [N_OUT*DATA_W-1:0]   m_tdata,
    output logic [N_OUT-1:0]          m_tvalid,
    output logic [N_OUT-1:0]          m_tlast,
    input  logic [N_OUT-1:0]          m_tready,
    output logic [15:0]               drop_cnt,
    output logic                      dbg_locked
);

    // Handshake: a beat moves on any edge where valid && ready; valid never depends on ready,
    // and s_tready is high when the holding register is empty or its beat drains this cycle.

    logic [N_OUT-1:0]  ov_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;
    logic [SEL_W-1:0]  dest;
    logic              dest_ok;
    logic [N_OUT-1:0]  dest_onehot;
    logic              drain;
    logic              accept;

    assign drain    = |(m_tready & ov_q);
    assign s_tready = ~(|ov_q) | drain;
    assign accept   = s_tvalid & s_tready;

`ifdef AXIS_DEMUX_PKT_LOCK_EN
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] lock_ch_q, lock_ch_d;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            lock_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    // A single-beat packet (s_tlast on the first beat) never enters LOCKED.
    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !s_tlast) begin
                    state_d   = ST_LOCKED;
                    lock_ch_d = demux_sel;
                end
            end
            ST_LOCKED: begin
                if (accept && s_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dest       = (state_q == ST_LOCKED) ? lock_ch_q : demux_sel;
    assign dbg_locked = (state_q == ST_LOCKED);
`else
    assign dest       = demux_sel;
    assign dbg_locked = 1'b0;
`endif

    assign dest_ok = (32'(dest) < N_OUT);

    always_comb begin
        dest_onehot = '0;
        for (int k = 0; k < N_OUT; k++) begin
            dest_onehot[k] = (32'(dest) == k);
        end
    end

    // Accepting a beat implies the register is empty or draining, so ov can be overwritten freely.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ov_q     <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            drop_cnt <= '0;
        end else if (accept) begin
            if (dest_ok) begin
                ov_q   <= dest_onehot;
                data_q <= s_tdata;
                last_q <= s_tlast;
            end else begin
                ov_q <= '0;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end else if (drain) begin
            ov_q <= '0;
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        assign m_tdata[k*DATA_W +: DATA_W] = data_q;
    end

    assign m_tvalid = ov_q;
    assign m_tlast  = ov_q & {N_OUT{last_q}};

endmodule

// File: tb/tb_axis_demux_n.sv
// Randomised bench for axis_demux_n against a queue-based model of the held beat, lock and drop counter.
// Lock-specific scenarios run only when AXIS_DEMUX_PKT_LOCK_EN is defined.
module tb_axis_demux_n;

    localparam int DATA_W = 32;
    localparam int N_OUT  = 3;
    localparam int SEL_W  = $clog2(N_OUT);
    localparam int W      = 4 + 1 + DATA_W;
`ifdef AXIS_DEMUX_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic                    aclk;
    logic                    aresetn;
    logic [SEL_W-1:0]        demux_sel;
    logic [DATA_W-1:0]       s_tdata;
    logic                    s_tvalid;
    logic                    s_tlast;
    logic                    s_tready;
    logic [N_OUT*DATA_W-1:0] m_tdata;
    logic [N_OUT-1:0]        m_tvalid;
    logic [N_OUT-1:0]        m_tlast;
    logic [N_OUT-1:0]        m_tready;
    logic [15:0]             drop_cnt;
    logic                    dbg_locked;

    axis_demux_n #(.DATA_W(DATA_W), .N_OUT(N_OUT)) dut (
        .aclk(aclk), .aresetn(aresetn), .demux_sel(demux_sel),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .drop_cnt(drop_cnt), .dbg_locked(dbg_locked)
    );

    // clock / reset
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // scoreboard: beats accepted for a real channel but not yet consumed, entry = {ch, last, data}
    logic [W-1:0]      exp_q[$];
    logic [DATA_W-1:0] model_data;
    logic [15:0]       model_drop;
    logic              model_locked;
    logic [SEL_W-1:0]  model_lock_ch;
    int                checks;
    int                errors;

    task automatic model_clear();
        exp_q.delete();
        model_data    = '0;
        model_drop    = '0;
        model_locked  = 1'b0;
        model_lock_ch = '0;
    endtask

    // One clock cycle: drive at the falling edge, check outputs against the model, then advance the model.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic [SEL_W-1:0] sel,
                         input logic l, input logic [N_OUT-1:0] rdy);
        logic [W-1:0]            f;
        logic [N_OUT-1:0]        ev;
        logic                    el;
        logic                    er;
        logic [SEL_W-1:0]        dst;
        logic [N_OUT*DATA_W-1:0] ed;
        int                      ch;
        @(negedge aclk);
        s_tvalid = v; s_tdata = d; demux_sel = sel; s_tlast = l; m_tready = rdy;
        #1;
        ev = '0; el = 1'b0; ch = 0; f = '0;
        if (exp_q.size() > 0) begin
            f  = exp_q[0];
            ch = int'(f[W-1 -: 4]);
            ev[ch] = 1'b1;
            el = f[DATA_W];
        end
        er = (exp_q.size() == 0) ? 1'b1 : rdy[ch];
        ed = {N_OUT{model_data}};
        checks++;
        if (m_tvalid !== ev) begin errors++; $display("FAIL m_tvalid got=%b exp=%b t=%0t", m_tvalid, ev, $time); end
        checks++;
        if (m_tlast !== (el ? ev : '0)) begin errors++; $display("FAIL m_tlast got=%b exp=%b t=%0t", m_tlast, (el ? ev : '0), $time); end
        checks++;
        if (m_tdata !== ed) begin errors++; $display("FAIL m_tdata got=%h exp=%h t=%0t", m_tdata, ed, $time); end
        checks++;
        if (s_tready !== er) begin errors++; $display("FAIL s_tready got=%b exp=%b t=%0t", s_tready, er, $time); end
        checks++;
        if (drop_cnt !== model_drop) begin errors++; $display("FAIL drop_cnt got=%h exp=%h t=%0t", drop_cnt, model_drop, $time); end
        checks++;
        if (dbg_locked !== (LOCK && model_locked)) begin errors++; $display("FAIL dbg_locked got=%b exp=%b t=%0t", dbg_locked, (LOCK && model_locked), $time); end
        if (exp_q.size() > 0 && rdy[ch]) void'(exp_q.pop_front());
        if (v && er) begin
            dst = (LOCK && model_locked) ? model_lock_ch : sel;
            if (int'(dst) < N_OUT) begin
                exp_q.push_back({4'(dst), l, d});
                model_data = d;
            end else if (model_drop != 16'hFFFF) begin
                model_drop = model_drop + 16'd1;
            end
            if (!model_locked && !l) begin
                model_locked  = 1'b1;
                model_lock_ch = sel;
            end else if (model_locked && l) begin
                model_locked = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '1);
    endtask

    task automatic test_reset();
        aresetn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; demux_sel = '0; s_tlast = 1'b0; m_tready = '0;
        model_clear();
        #23;
        checks++;
        if (m_tvalid !== '0 || m_tlast !== '0) begin errors++; $display("FAIL reset_valid_last got=%b/%b exp=0/0", m_tvalid, m_tlast); end
        checks++;
        if (m_tdata !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", m_tdata); end
        checks++;
        if (drop_cnt !== 16'h0 || s_tready !== 1'b1) begin errors++; $display("FAIL reset_cnt_ready got=%h/%b exp=0/1", drop_cnt, s_tready); end
        @(negedge aclk);
        aresetn = 1'b1;
        idle(2);
    endtask

    task automatic test_routing();
        logic [SEL_W-1:0] sels[6];
        sels = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        for (int i = 0; i < 6; i++) cycle(1'b1, DATA_W'(32'hA0 + i), sels[i], 1'b1, '1);
        idle(2);
        checks++;
        if (drop_cnt !== 16'h0) begin errors++; $display("FAIL routing_drop got=%h exp=0", drop_cnt); end
    endtask

    task automatic test_back_pressure();
        cycle(1'b1, 32'h11, 2'd1, 1'b1, 3'b101);
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h22, 2'd0, 1'b1, 3'b101);
        cycle(1'b1, 32'h22, 2'd0, 1'b1, 3'b111);
        idle(2);
    endtask

    task automatic test_discard();
        logic [15:0] start;
        start = model_drop;
        for (int i = 0; i < 5; i++) cycle(1'b1, DATA_W'(32'hD0 + i), 2'd3, 1'b1, '1);
        idle(1);
        checks++;
        if (drop_cnt !== start + 16'd5) begin errors++; $display("FAIL discard_cnt got=%h exp=%h", drop_cnt, start + 16'd5); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), DATA_W'($urandom), SEL_W'($urandom_range(0, 3)),
                  1'($urandom_range(0, 2) == 0), N_OUT'($urandom_range(0, 7)));
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, DATA_W'($urandom), 2'd0, 1'b1, '1);
        idle(3);
    endtask

    task automatic test_lock();
        logic [SEL_W-1:0] sels[4];
        sels = '{2'd2, 2'd2, 2'd0, 2'd0};
        for (int i = 0; i < 4; i++) cycle(1'b1, DATA_W'(32'hB0 + i), sels[i], 1'(i == 3), '1);
        cycle(1'b1, 32'hC0, 2'd0, 1'b1, '1);
        idle(2);
        for (int i = 0; i < 3; i++) cycle(1'b1, DATA_W'(32'hE0 + i), 2'd3, 1'(i == 2), '1);
        idle(2);
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 32'h77, 2'd1, 1'b0, 3'b000);
        @(negedge aclk);
        s_tvalid = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== '0 || m_tlast !== '0) begin errors++; $display("FAIL midreset_valid got=%b/%b exp=0/0", m_tvalid, m_tlast); end
        checks++;
        if (drop_cnt !== 16'h0 || dbg_locked !== 1'b0) begin errors++; $display("FAIL midreset_cnt_lock got=%h/%b exp=0/0", drop_cnt, dbg_locked); end
        model_clear();
        @(negedge aclk);
        aresetn = 1'b1;
        cycle(1'b1, 32'h55, 2'd0, 1'b1, '1);
        idle(2);
    endtask

    task automatic test_saturation();
        int n1;
        n1 = 65534 - int'(model_drop);
        @(negedge aclk);
        s_tvalid = 1'b1; demux_sel = 2'd3; s_tlast = 1'b1; m_tready = '1;
        repeat (n1) @(negedge aclk);
        checks++;
        if (drop_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe got=%h exp=fffe", drop_cnt); end
        @(negedge aclk);
        checks++;
        if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff got=%h exp=ffff", drop_cnt); end
        repeat (5) @(negedge aclk);
        checks++;
        if (drop_cnt !== 16'hFFFF || m_tvalid !== '0) begin errors++; $display("FAIL sat_hold got=%h/%b exp=ffff/0", drop_cnt, m_tvalid); end
        s_tvalid = 1'b0;
        model_drop = 16'hFFFF;
        idle(2);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_routing();
        test_back_pressure();
        test_discard();
        test_random();
        if (LOCK) test_lock();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
